// File: rtl/fc_mac_core.sv
// fc_mac_core: fully-connected MAC core. Accumulates activation/weight beats
// into a batch_size x bias_size array of Q16.16 dot products, adds the
// per-neuron bias and presents the finished array with a one-cycle strobe.
//
// Handshake: a beat transfers on a rising edge where RdFc_valid and
// FcRd_ready are both high. FcRd_ready is a pure function of the registered
// state (high only in ACC), so it never depends combinationally on
// RdFc_valid; the producer may hold or drop valid freely between beats.
module fc_mac_core #(
  parameter int batch_size = 2,
  parameter int bias_size  = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               NcFc_start,
  input  logic [15:0]                        NcFc_len,
  input  logic                               NcFc_bias_en,
  input  logic [bias_size*32-1:0]            NcFc_bias,
  input  logic                               RdFc_valid,
  output logic                               FcRd_ready,
  input  logic [batch_size*32-1:0]           RdFc_x,
  input  logic [bias_size*32-1:0]            RdFc_w,
  output logic                               FcNwc_result_en,
  output logic [batch_size*bias_size*32-1:0] FcNwc_result,
  output logic                               FcNc_busy,
  output logic [1:0]                         dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    BIAS = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] len_reg;
  logic [15:0] cnt;
  logic        beat_fire;
  logic        last_beat;

  logic [31:0] bias_reg [bias_size];
  logic [31:0] acc      [batch_size][bias_size];
  logic [63:0] x_ext    [batch_size];
  logic [63:0] w_ext    [bias_size];
  logic [31:0] prod_q   [batch_size][bias_size];
  logic [31:0] acc_mac  [batch_size][bias_size];
  logic [31:0] acc_bias [batch_size][bias_size];

  assign FcRd_ready      = (state == ACC);
  assign FcNc_busy       = (state != IDLE);
  assign FcNwc_result_en = (state == OUT);
  assign dbg_state       = state;
  assign beat_fire       = RdFc_valid & FcRd_ready;
  assign last_beat       = ((cnt + 16'd1) == len_reg);

  // Sign-extend each lane to 64 bits so the low half of the product is the
  // exact signed 32x32 result.
  always_comb begin
    for (int b = 0; b < batch_size; b++) begin
      x_ext[b] = {{32{RdFc_x[b*32+31]}}, RdFc_x[b*32 +: 32]};
    end
    for (int o = 0; o < bias_size; o++) begin
      w_ext[o] = {{32{RdFc_w[o*32+31]}}, RdFc_w[o*32 +: 32]};
    end
  end

  // Q16.16 product keeps bits [47:16] (floor shift); sums wrap at 32 bits.
  always_comb begin
    for (int b = 0; b < batch_size; b++) begin
      for (int o = 0; o < bias_size; o++) begin
        prod_q[b][o]   = 32'((x_ext[b] * w_ext[o]) >> 16);
        acc_mac[b][o]  = acc[b][o] + prod_q[b][o];
        acc_bias[b][o] = acc[b][o] + bias_reg[o];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (NcFc_start) begin
          state_next = (NcFc_len == 16'd0) ? BIAS : ACC;
        end
      end
      ACC: begin
        if (beat_fire && last_beat) begin
          state_next = BIAS;
        end
      end
      BIAS:    state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: bias load, job setup, accumulation and result capture. The
  // result register is written on the BIAS->OUT edge so it is already valid
  // while the strobe is high, and it holds until the next job's OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_reg      <= 16'd0;
      cnt          <= 16'd0;
      FcNwc_result <= '0;
      for (int o = 0; o < bias_size; o++) begin
        bias_reg[o] <= 32'd0;
      end
      for (int b = 0; b < batch_size; b++) begin
        for (int o = 0; o < bias_size; o++) begin
          acc[b][o] <= 32'd0;
        end
      end
    end else begin
      if (NcFc_bias_en) begin
        for (int o = 0; o < bias_size; o++) begin
          bias_reg[o] <= NcFc_bias[o*32 +: 32];
        end
      end
      case (state)
        IDLE: begin
          if (NcFc_start) begin
            len_reg <= NcFc_len;
            cnt     <= 16'd0;
            for (int b = 0; b < batch_size; b++) begin
              for (int o = 0; o < bias_size; o++) begin
                acc[b][o] <= 32'd0;
              end
            end
          end
        end
        ACC: begin
          if (beat_fire) begin
            cnt <= cnt + 16'd1;
            for (int b = 0; b < batch_size; b++) begin
              for (int o = 0; o < bias_size; o++) begin
                acc[b][o] <= acc_mac[b][o];
              end
            end
          end
        end
        BIAS: begin
          for (int b = 0; b < batch_size; b++) begin
            for (int o = 0; o < bias_size; o++) begin
              acc[b][o] <= acc_bias[b][o];
              FcNwc_result[(b*bias_size+o)*32 +: 32] <= acc_bias[b][o];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_mac_core.sv
// Bench for fc_mac_core: directed jobs with hand-computed results, plus
// random jobs checked against a Q16.16 arithmetic model of the layer.
module tb_fc_mac_core;

  localparam int NB = 2;
  localparam int NO = 2;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 NcFc_start = 1'b0;
  logic [15:0]          NcFc_len = 16'd0;
  logic                 NcFc_bias_en = 1'b0;
  logic [NO*32-1:0]     NcFc_bias = '0;
  logic                 RdFc_valid = 1'b0;
  logic                 FcRd_ready;
  logic [NB*32-1:0]     RdFc_x = '0;
  logic [NO*32-1:0]     RdFc_w = '0;
  logic                 FcNwc_result_en;
  logic [NB*NO*32-1:0]  FcNwc_result;
  logic                 FcNc_busy;
  logic [1:0]           dbg_state;

  fc_mac_core #(.batch_size(NB), .bias_size(NO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .NcFc_start      (NcFc_start),
    .NcFc_len        (NcFc_len),
    .NcFc_bias_en    (NcFc_bias_en),
    .NcFc_bias       (NcFc_bias),
    .RdFc_valid      (RdFc_valid),
    .FcRd_ready      (FcRd_ready),
    .RdFc_x          (RdFc_x),
    .RdFc_w          (RdFc_w),
    .FcNwc_result_en (FcNwc_result_en),
    .FcNwc_result    (FcNwc_result),
    .FcNc_busy       (FcNc_busy),
    .dbg_state       (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int strobe_count = 0;

  logic [31:0] exp_q[$];
  logic [63:0] beat_x_q[$];
  logic [63:0] beat_w_q[$];
  logic [31:0] bias_model[NO];
  logic [31:0] last_res[NB*NO];

  // Strobe counter: sampled on the edge, before the state register moves.
  always @(posedge clk) begin
    if (FcNwc_result_en === 1'b1) strobe_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Q16.16 multiply: exact product, floor-divide by 2^16, keep 32 bits.
  function automatic logic [31:0] q_mul(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint p;
    sa = $signed(a);
    sb = $signed(b);
    p = sa * sb;
    return 32'(p >>> 16);
  endfunction

  // Reference: result[b][o] = bias[o] + sum over beats of q_mul(x[b], w[o]).
  task automatic model_fill(input int len);
    logic [31:0] sum;
    logic [63:0] xv;
    logic [63:0] wv;
    for (int b = 0; b < NB; b++) begin
      for (int o = 0; o < NO; o++) begin
        sum = bias_model[o];
        for (int k = 0; k < len; k++) begin
          xv = beat_x_q[k];
          wv = beat_w_q[k];
          sum = sum + q_mul(xv[b*32 +: 32], wv[o*32 +: 32]);
        end
        exp_q.push_back(sum);
      end
    end
  endtask

  task automatic load_bias(input logic [31:0] b0, input logic [31:0] b1);
    NcFc_bias_en = 1'b1;
    NcFc_bias = {b1, b0};
    tick();
    NcFc_bias_en = 1'b0;
    bias_model[0] = b0;
    bias_model[1] = b1;
  endtask

  task automatic random_beats(input int len);
    beat_x_q.delete();
    beat_w_q.delete();
    for (int k = 0; k < len; k++) begin
      beat_x_q.push_back({$urandom, $urandom});
      beat_w_q.push_back({$urandom, $urandom});
    end
  endtask

  // One job from start to the idle cycle after the strobe. gap_mode:
  // 0 = valid every cycle, 1 = valid every other cycle, 2 = random valid.
  // poke drives start, beats and a bias load while the job is in BIAS/OUT.
  task automatic run_job(input int len, input int gap_mode, input bit poke, input string tag);
    int idx;
    int cyc;
    int s0;
    logic fire;
    logic [31:0] poke_b0;
    logic [31:0] poke_b1;
    s0 = strobe_count;
    NcFc_start = 1'b1;
    NcFc_len = 16'(len);
    tick();
    NcFc_start = 1'b0;
    check({tag, "_busy_t1"}, 32'(FcNc_busy), 32'd1);
    check({tag, "_ready_t1"}, 32'(FcRd_ready), 32'(len != 0));
    idx = 0;
    cyc = 0;
    while (idx < len && cyc < len * 4 + 50) begin
      case (gap_mode)
        0:       RdFc_valid = 1'b1;
        1:       RdFc_valid = (cyc % 2 == 0);
        default: RdFc_valid = 1'($urandom_range(0, 1));
      endcase
      RdFc_x = beat_x_q[idx];
      RdFc_w = beat_w_q[idx];
      fire = FcRd_ready && RdFc_valid;
      tick();
      if (fire) idx++;
      cyc++;
    end
    RdFc_valid = 1'b0;
    RdFc_x = {$urandom, $urandom};
    RdFc_w = {$urandom, $urandom};
    check({tag, "_beats"}, 32'(idx), 32'(len));
    // Cycle after the last beat: BIAS.
    check({tag, "_bias_ready"}, 32'(FcRd_ready), 32'd0);
    check({tag, "_bias_strobe"}, 32'(FcNwc_result_en), 32'd0);
    check({tag, "_bias_busy"}, 32'(FcNc_busy), 32'd1);
    poke_b0 = $urandom;
    poke_b1 = $urandom;
    if (poke) begin
      NcFc_start = 1'b1;
      NcFc_len = 16'd3;
      NcFc_bias_en = 1'b1;
      NcFc_bias = {poke_b1, poke_b0};
      RdFc_valid = 1'b1;
    end
    tick();
    NcFc_bias_en = 1'b0;
    // OUT: strobe with the finished array.
    check({tag, "_out_strobe"}, 32'(FcNwc_result_en), 32'd1);
    check({tag, "_out_ready"}, 32'(FcRd_ready), 32'd0);
    for (int i = 0; i < NB * NO; i++) begin
      last_res[i] = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      check($sformatf("%s_res%0d", tag, i), FcNwc_result[i*32 +: 32], last_res[i]);
    end
    tick();
    NcFc_start = 1'b0;
    RdFc_valid = 1'b0;
    if (poke) begin
      bias_model[0] = poke_b0;
      bias_model[1] = poke_b1;
    end
    check({tag, "_idle_busy"}, 32'(FcNc_busy), 32'd0);
    check({tag, "_idle_strobe"}, 32'(FcNwc_result_en), 32'd0);
    check({tag, "_strobes"}, 32'(strobe_count - s0), 32'd1);
    for (int i = 0; i < NB * NO; i++) begin
      check($sformatf("%s_hold%0d", tag, i), FcNwc_result[i*32 +: 32], last_res[i]);
    end
  endtask

  initial begin
    int s0;
    int len;
    bias_model[0] = 32'd0;
    bias_model[1] = 32'd0;

    // Reset values.
    repeat (2) tick();
    check("rst_ready", 32'(FcRd_ready), 32'd0);
    check("rst_strobe", 32'(FcNwc_result_en), 32'd0);
    check("rst_busy", 32'(FcNc_busy), 32'd0);
    for (int i = 0; i < NB * NO; i++) begin
      check($sformatf("rst_res%0d", i), FcNwc_result[i*32 +: 32], 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // Basic MAC: rows {3.0, 2.5} and {4.0, 3.0}.
    load_bias(32'd0, 32'd0);
    beat_x_q = '{{32'h0002_0000, 32'h0001_0000}, {32'h0001_0000, 32'h0001_0000}};
    beat_w_q = '{{32'h0000_8000, 32'h0001_0000}, {32'h0002_0000, 32'h0002_0000}};
    exp_q = '{32'h0003_0000, 32'h0002_8000, 32'h0004_0000, 32'h0003_0000};
    run_job(2, 0, 1'b0, "basic");

    // Bias and negatives: rows {-4.0, -2.5} and {-1.0, 0.5}.
    load_bias(32'hFFFF_0000, 32'h0000_8000);
    beat_x_q = '{{32'h0000_0000, 32'hFFFE_0000}};
    beat_w_q = '{{32'h0001_8000, 32'h0001_8000}};
    exp_q = '{32'hFFFC_0000, 32'hFFFD_8000, 32'hFFFF_0000, 32'h0000_8000};
    run_job(1, 0, 1'b0, "bias_neg");

    // Backpressure: same beats gap-free and with valid every other cycle.
    load_bias($urandom, $urandom);
    random_beats(4);
    model_fill(4);
    run_job(4, 0, 1'b0, "nogap");
    model_fill(4);
    run_job(4, 1, 1'b0, "gap");

    // len = 0, with a start and a same-cycle bias load poked during BIAS/OUT.
    load_bias(32'd5, 32'd7);
    beat_x_q.delete();
    beat_w_q.delete();
    exp_q = '{32'd5, 32'd7, 32'd5, 32'd7};
    run_job(0, 0, 1'b1, "len0");

    // Wrap: 0x7FFF0000 + 2.0 = 0x80010000.
    load_bias(32'd0, 32'd0);
    beat_x_q = '{{32'h0, 32'h7FFF_0000}, {32'h0, 32'h0002_0000}};
    beat_w_q = '{{32'h0, 32'h0001_0000}, {32'h0, 32'h0001_0000}};
    exp_q = '{32'h8001_0000, 32'h0, 32'h0, 32'h0};
    run_job(2, 2, 1'b0, "wrap");

    // Reset during ACC after 3 of 8 beats.
    load_bias(32'h0001_0000, 32'h0002_0000);
    random_beats(8);
    s0 = strobe_count;
    NcFc_start = 1'b1;
    NcFc_len = 16'd8;
    tick();
    NcFc_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      RdFc_valid = 1'b1;
      RdFc_x = beat_x_q[k];
      RdFc_w = beat_w_q[k];
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(FcRd_ready), 32'd0);
    check("mid_rst_busy", 32'(FcNc_busy), 32'd0);
    check("mid_rst_strobe", 32'(FcNwc_result_en), 32'd0);
    for (int i = 0; i < NB * NO; i++) begin
      check($sformatf("mid_rst_res%0d", i), FcNwc_result[i*32 +: 32], 32'd0);
    end
    repeat (3) tick();
    RdFc_valid = 1'b0;
    rst_n = 1'b1;
    bias_model[0] = 32'd0;
    bias_model[1] = 32'd0;
    tick();
    check("mid_rst_strobes", 32'(strobe_count - s0), 32'd0);
    random_beats(1);
    model_fill(1);
    run_job(1, 0, 1'b0, "after_rst");

    // Random jobs.
    for (int j = 0; j < 6; j++) begin
      if ($urandom_range(0, 1) == 1) load_bias($urandom, $urandom);
      len = $urandom_range(1, 6);
      random_beats(len);
      model_fill(len);
      run_job(len, 2, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", j));
    end

    // Longest job: len = 0xFFFF.
    load_bias(32'd0, 32'd0);
    beat_x_q.delete();
    beat_w_q.delete();
    for (int k = 0; k < 65535; k++) begin
      beat_x_q.push_back({32'h0001_0000, 32'hFFFF_0000});
      beat_w_q.push_back({32'h0001_0000, 32'h0002_0000});
    end
    model_fill(65535);
    run_job(65535, 0, 1'b0, "len_max");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
